// File: rtl/seg_scan_counter_if.sv
// Bundle between the counter/display core and its user: count controls in,
// multiplexed segment/anode drive and counter status out.
interface seg_scan_counter_if #(
  parameter int DIGITS = 8
);
  logic                  cnt_en;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic [4*DIGITS-1:0]   value;
  logic                  wrap;

  modport master (
    output cnt_en, up_dn, load, load_val,
    input  seg, an, value, wrap
  );

  modport slave (
    input  cnt_en, up_dn, load, load_val,
    output seg, an, value, wrap
  );
endinterface

// File: rtl/seg_scan_counter.sv
// Multi-digit BCD/hex up/down counter with prescaled stepping and a
// time-multiplexed active-low seven-segment display driver.
module seg_scan_counter #(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 16777216,
  parameter int SCAN_DIV = 4096,
  parameter int HEX      = 0,
  parameter int LZB      = 1
) (
  input logic              clk,
  input logic              rst,
  seg_scan_counter_if.slave bus
);

  localparam int VW = 4 * DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]    DMAX      = (HEX != 0) ? 4'd15 : 4'd9;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]     r_tick_cnt;
  logic [SW-1:0]     r_scan_cnt;
  logic [IW-1:0]     r_idx;
  logic [VW-1:0]     r_value;
  logic              r_wrap;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  logic              w_tick;
  logic              w_scan_adv;
  logic [VW-1:0]     w_step_val;
  logic              w_step_carry;
  logic [VW-1:0]     w_load_clamped;
  logic [3:0]        w_digit;
  logic              w_blank;

  function automatic logic [7:0] f_encode(input logic [3:0] d);
    case (d)
      4'h0: f_encode = 8'hC0;
      4'h1: f_encode = 8'hF9;
      4'h2: f_encode = 8'hA4;
      4'h3: f_encode = 8'hB0;
      4'h4: f_encode = 8'h99;
      4'h5: f_encode = 8'h92;
      4'h6: f_encode = 8'h82;
      4'h7: f_encode = 8'hF8;
      4'h8: f_encode = 8'h80;
      4'h9: f_encode = 8'h90;
      4'hA: f_encode = 8'h88;
      4'hB: f_encode = 8'h83;
      4'hC: f_encode = 8'hC6;
      4'hD: f_encode = 8'hA1;
      4'hE: f_encode = 8'h86;
      default: f_encode = 8'h8E;
    endcase
  endfunction

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_scan_adv = (r_scan_cnt == SCAN_LAST);

  // Ripple step; a carry/borrow surviving past the top digit is the wrap.
  always_comb begin
    w_step_val   = r_value;
    w_step_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_step_carry) begin
        if (bus.up_dn) begin
          if (r_value[4*i +: 4] == DMAX) begin
            w_step_val[4*i +: 4] = 4'd0;
          end else begin
            w_step_val[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
            w_step_carry         = 1'b0;
          end
        end else begin
          if (r_value[4*i +: 4] == 4'd0) begin
            w_step_val[4*i +: 4] = DMAX;
          end else begin
            w_step_val[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
            w_step_carry         = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_load_clamped = bus.load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if ((HEX == 0) && (bus.load_val[4*i +: 4] > 4'd9)) begin
        w_load_clamped[4*i +: 4] = 4'd9;
      end
    end
  end

  // Blank when leading-zero suppression is on and this and every higher digit is zero.
  always_comb begin
    w_digit = 4'd0;
    w_blank = (LZB != 0) && (r_idx != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit = r_value[4*i +: 4];
      end
      if ((IW'(i) >= r_idx) && (r_value[4*i +: 4] != 4'd0)) begin
        w_blank = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_value    <= '0;
      r_wrap     <= 1'b0;
      r_seg      <= 8'hFF;
      r_an       <= '1;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_wrap     <= 1'b0;
      if (bus.load) begin
        r_value <= w_load_clamped;
      end else if (bus.cnt_en && w_tick) begin
        r_value <= w_step_val;
        r_wrap  <= w_step_carry;
      end
      if (w_scan_adv) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
      // seg and an are registered together so a digit never lands on the wrong anode.
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_blank ? 8'hFF : f_encode(w_digit);
    end
  end

  assign bus.seg   = r_seg;
  assign bus.an    = r_an;
  assign bus.value = r_value;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Drives three counter configurations (BCD, hex, BCD with zero blanking) from
// one stimulus stream and checks each against an arithmetic reference model.
module tb_seg_scan_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;

  always #5 clk = ~clk;

  seg_scan_counter_if #(.DIGITS(4)) if0 (), if1 (), if2 ();

  assign if0.cnt_en = cnt_en;  assign if0.up_dn = up_dn;
  assign if0.load = load;      assign if0.load_val = load_val;
  assign if1.cnt_en = cnt_en;  assign if1.up_dn = up_dn;
  assign if1.load = load;      assign if1.load_val = load_val;
  assign if2.cnt_en = cnt_en;  assign if2.up_dn = up_dn;
  assign if2.load = load;      assign if2.load_val = load_val;

  seg_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .HEX(0), .LZB(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  seg_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .HEX(1), .LZB(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  seg_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .HEX(0), .LZB(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [7:0]  o_seg [3];
  logic [3:0]  o_an  [3];
  logic [15:0] o_val [3];
  logic        o_wrap[3];
  assign o_seg[0] = if0.seg;  assign o_an[0] = if0.an;  assign o_val[0] = if0.value;  assign o_wrap[0] = if0.wrap;
  assign o_seg[1] = if1.seg;  assign o_an[1] = if1.an;  assign o_val[1] = if1.value;  assign o_wrap[1] = if1.wrap;
  assign o_seg[2] = if2.seg;  assign o_an[2] = if2.an;  assign o_val[2] = if2.value;  assign o_wrap[2] = if2.wrap;

  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         chk_on = 0;
  int         m_val [3];
  bit         m_wrap[3];
  logic [7:0] m_seg [3];
  logic [3:0] m_an;
  int         m_tcnt, m_scnt, m_idx;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic int to_n(input int v, input int b);
    int n = 0;
    for (int i = 3; i >= 0; i--) n = n * b + ((v >> (4 * i)) & 15);
    return n;
  endfunction

  function automatic int from_n(input int n, input int b);
    int v = 0;
    for (int i = 0; i < 4; i++) begin
      v = v | ((n % b) << (4 * i));
      n = n / b;
    end
    return v;
  endfunction

  function automatic int clamp(input int v, input bit bcd);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      int d = (v >> (4 * i)) & 15;
      if (bcd && d > 9) d = 9;
      r = r | (d << (4 * i));
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input int v, input int idx, input bit lzb);
    if (lzb && idx > 0 && (v >> (4 * idx)) == 0) return 8'hFF;
    return enc((v >> (4 * idx)) & 15);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic cyc();
    logic [7:0] nseg[3];
    logic [3:0] nan;
    int base, lim, n;
    bit tick;
    @(posedge clk);
    nan = ~(4'b0001 << m_idx);
    for (int k = 0; k < 3; k++) nseg[k] = seg_of(m_val[k], m_idx, k == 2);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_val[k] = 0; m_wrap[k] = 0; m_seg[k] = 8'hFF;
      end
      m_an = 4'hF; m_tcnt = 0; m_scnt = 0; m_idx = 0;
    end else begin
      tick = (m_tcnt == 3);
      for (int k = 0; k < 3; k++) begin
        base = (k == 1) ? 16 : 10;
        lim  = base ** 4;
        m_wrap[k] = 0;
        if (load) begin
          m_val[k] = clamp(int'(load_val), k != 1);
        end else if (cnt_en && tick) begin
          n = to_n(m_val[k], base) + (up_dn ? 1 : -1);
          m_wrap[k] = (n == lim) || (n < 0);
          m_val[k]  = from_n((n + lim) % lim, base);
        end
        m_seg[k] = nseg[k];
      end
      m_an   = nan;
      m_tcnt = (m_tcnt + 1) % 4;
      if (m_scnt == 1) begin
        m_scnt = 0;
        m_idx  = (m_idx + 1) % 4;
      end else begin
        m_scnt++;
      end
    end
    #1;
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("seg%0d", k),  o_seg[k],  m_seg[k]);
        chk($sformatf("an%0d", k),   o_an[k],   m_an);
        chk($sformatf("val%0d", k),  o_val[k],  m_val[k]);
        chk($sformatf("wrap%0d", k), o_wrap[k], m_wrap[k]);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic run_tick();
    for (int i = 0; i < 4 && m_tcnt != 3; i++) cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b1; cnt_en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    cyc();
    chk_on = 1;
    cyc();
    chk("rst_an", if0.an, 4'hF);
    chk("rst_seg", if0.seg, 8'hFF);

    rst = 1'b0;
    cyc();
    chk("first_an", if0.an, 4'hE);
    chk("first_seg", if0.seg, 8'hC0);
    repeat (9) cyc();

    rst = 1'b1;
    cyc();
    chk("midscan_rst_an", if0.an, 4'hF);
    chk("midscan_rst_seg", if0.seg, 8'hFF);
    rst = 1'b0;
    repeat (3) cyc();

    cnt_en = 1'b1; up_dn = 1'b1;
    do_load(16'h0099); run_tick();
    chk("bcd_carry", if0.value, 16'h0100);
    chk("bcd_carry_wrap", if0.wrap, 1'b0);
    do_load(16'h9999); run_tick();
    chk("bcd_wrap_val", if0.value, 16'h0000);
    chk("bcd_wrap", if0.wrap, 1'b1);
    cyc();
    chk("bcd_wrap_one_cycle", if0.wrap, 1'b0);

    up_dn = 1'b0;
    do_load(16'h0100); run_tick();
    chk("bcd_borrow", if0.value, 16'h0099);
    do_load(16'h0000); run_tick();
    chk("bcd_down_wrap_val", if0.value, 16'h9999);
    chk("bcd_down_wrap", if0.wrap, 1'b1);

    up_dn = 1'b1;
    do_load(16'h00FF); run_tick();
    chk("hex_up", if1.value, 16'h0100);

    cnt_en = 1'b0;
    do_load(16'h00A0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (m_an == 4'hD) chk("hex_seg_A", if1.seg, 8'h88);
    end

    cnt_en = 1'b1;
    for (int i = 0; i < 4 && m_tcnt != 3; i++) cyc();
    load = 1'b1; load_val = 16'h00C5;
    cyc();
    load = 1'b0;
    chk("prio_clamp", if0.value, 16'h0095);
    chk("prio_wrap", if0.wrap, 1'b0);
    chk("prio_hex", if1.value, 16'h00C5);

    cnt_en = 1'b0;
    do_load(16'h0050);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (m_an == 4'h7 || m_an == 4'hB) chk("lzb_blank", if2.seg, 8'hFF);
      if (m_an == 4'hD) chk("lzb_d1", if2.seg, 8'h92);
      if (m_an == 4'hE) chk("lzb_d0", if2.seg, 8'hC0);
    end
    do_load(16'h0000);
    repeat (10) cyc();

    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      load   = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: load_val = 16'h9999;
        1: load_val = 16'hFFFF;
        2: load_val = 16'h0000;
        default: load_val = 16'($urandom);
      endcase
      cnt_en = ($urandom_range(0, 3) != 0);
      up_dn  = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_counter.md
# seg_scan_counter

Parametrised multi-digit seven-segment counter display. It holds a DIGITS-wide BCD or hex counter that steps up or down once per prescaler tick. It time-multiplexes the digits onto one shared active-low segment bus with active-low digit enables. It sits between the board clock and the seven-segment header, and replaces the single-digit fixed-sequence display.

## Interface
- DIGITS, 8: number of displayed digits and counter digits (1..8).
- TICK_DIV, 16777216: clk cycles per count step (≥2).
- SCAN_DIV, 4096: clk cycles each digit stays enabled (≥1).
- HEX, 0: 0 = each digit counts 0..9 (BCD); 1 = each digit counts 0..F.
- LZB, 1: 1 = blank leading zeros (digit 0 is never blanked).
- clk  in  1  single system clock; everything is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- cnt_en  in  1  enables counting at prescaler ticks.
- up_dn  in  1  1 = count up, 0 = count down; sampled at the tick.
- load  in  1  synchronous load of load_val; highest priority after rst.
- load_val  in  4*DIGITS  digit i is bits [4i+3:4i]; digits >9 when HEX=0 are clamped to 9.
- seg  out  8  active-low segments, bit0=a … bit6=g, bit7=dp (always 1, off).
- an  out  DIGITS  active-low digit enables, one-hot-low.
- value  out  4*DIGITS  current counter contents.
- wrap  out  1  one-cycle pulse when a count step wraps.

## Operation
- Prescaler tick_cnt counts 0..TICK_DIV-1 and free-runs regardless of cnt_en. tick=1 in the cycle where tick_cnt==TICK_DIV-1.
- Counter update priority per cycle:
  1. rst: clear.
  2. load: value<=load_val, clamped.
  3. cnt_en&&tick: step.
  4. Otherwise hold.
- load does not reset the prescaler.
- Step is a digit-wise ripple. Digit max M=9 (HEX=0) or 15 (HEX=1).
  - Up: digit 0 increments; a digit at M rolls to 0 and carries.
  - Down: a digit at 0 rolls to M and borrows.
- Wrap:
  - Up from all-M produces all-0 and wrap=1 for one cycle.
  - Down from all-0 produces all-M and wrap=1.
  - wrap is registered, asserted the cycle after the tick edge, together with the new value.
- Scan: scan_cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1, idx advances by 1, wrapping DIGITS-1 to 0.
- Output register every cycle: an<=~(1<<idx); seg<=encode(value digit idx).
- Encoding: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- LZB=1: digit i>0 is blanked (seg=FF, an still driven) when it and all higher digits are 0.
- DIGITS=1: an stays 0 after the first post-reset cycle; idx is constant 0.

## Timing
- Reset values: seg=8'hFF, an=all 1s, value=0, wrap=0, tick_cnt=0, scan_cnt=0, idx=0.
- rst asserted mid-count or mid-scan: all state returns to reset values at that edge. No partial step or wrap pulse is produced.
- First cycle after rst deasserts: an=~1, seg=encode(0)=C0.
- seg/an lag idx/value by exactly 1 cycle. seg and an always change on the same edge, so they never show a digit on the wrong anode.
- Count latency: value and wrap change on the edge ending the tick cycle. They appear on seg at the next edge if that digit is selected.
- First tick occurs TICK_DIV cycles after reset release.
- load and tick in the same cycle: load wins, no step, wrap=0.
- cnt_en low at the tick: no step; the prescaler continues.
- up_dn and cnt_en are sampled only in the tick cycle.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=4, SCAN_DIV=2, HEX=0, LZB=0 unless noted.
- Reset/scan: release rst, hold cnt_en=0.
  - an sequence is E,E,D,D,B,B,7,7,E…
  - seg=C0 throughout.
  - Assert rst mid-scan → an=F, seg=FF the next cycle.
- BCD up with carry: load 0x0099, cnt_en=1, up_dn=1.
  - After the next tick, value=0x0100 and wrap=0.
  - Load 0x9999 → after the tick, value=0x0000 and wrap is high for exactly 1 cycle.
- Down/borrow: load 0x0100, up_dn=0 → value=0x0099 after the tick.
  - Load 0x0000 → value=0x9999 and wrap=1.
- HEX=1: load 0x00FF, count up → value=0x0100.
  - While digit 1 is scanned with value 0x00A0, seg=88.
- Priority/clamp: assert load with load_val=0x00C5 in the tick cycle with cnt_en=1 → value=0x0095, no step, wrap=0.
- LZB=1: value=0x0050.
  - For digits 3 and 2: seg=FF with an low.
  - Digit 1: seg=92. Digit 0: seg=C0.
  - value=0x0000 → only digit 0 shows C0.
